// File: rtl/graphics_pkg.sv
// Shared VGA 640x480 timing constants and a palette-entry extraction helper
// for the graphics compositor.
package graphics_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;
  localparam int V_TOTAL      = 525;

  // Widest supported palette: 8 layers of 3 channels of 8 bits.
  localparam int COLOR_MAX_W = 3 * 8;
  localparam int PAL_MAX_W   = 8 * COLOR_MAX_W;

  // Returns the {R,G,B} entry of layer k, zero-extended to COLOR_MAX_W.
  function automatic logic [COLOR_MAX_W-1:0] color_slice(
    input logic [PAL_MAX_W-1:0] pal,
    input int unsigned          k,
    input int unsigned          color_w
  );
    logic [PAL_MAX_W-1:0] shifted;
    logic [PAL_MAX_W-1:0] mask;
    shifted = pal >> (k * 3 * color_w);
    mask    = (PAL_MAX_W'(1) << (3 * color_w)) - PAL_MAX_W'(1);
    return COLOR_MAX_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/graphics_compositor_vga_timing.sv
// VGA 640x480 raster counters with active-low syncs and the active-area flag.
module vga_timing
  import graphics_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
    end else if (hpos == 10'(H_TOTAL - 1)) begin
      hpos <= '0;
      vpos <= (vpos == 10'(V_TOTAL - 1)) ? '0 : vpos + 10'd1;
    end else begin
      hpos <= hpos + 10'd1;
    end
  end

  assign hsync      = !(hpos >= 10'(H_SYNC_START) && hpos <= 10'(H_SYNC_END));
  assign vsync      = !(vpos >= 10'(V_SYNC_START) && vpos <= 10'(V_SYNC_END));
  assign display_on = (hpos < 10'(H_ACTIVE)) && (vpos < 10'(V_ACTIVE));

endmodule

// File: rtl/graphics_compositor.sv
// Prioritised layer compositor on VGA timing: 2-stage colour pipeline with
// aligned syncs, frame/game/line ticks and a first-hit collision capture.
module graphics_compositor
  import graphics_pkg::*;
#(
  parameter int                  N_LAYERS    = 4,
  parameter int                  COLOR_W     = 2,
  parameter int                  CONV        = 0,
  parameter int                  TICK_DIV    = 3,
  parameter int                  LINE_BIT    = 5,
  parameter logic [N_LAYERS-1:0] COLL_MASK_A = N_LAYERS'(4'b0010),
  parameter logic [N_LAYERS-1:0] COLL_MASK_B = N_LAYERS'(4'b0001)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_LAYERS-1:0]             i_layer_on,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   i_palette,
  input  logic [3*COLOR_W-1:0]            i_bg_color,
  input  logic                            i_game_start_pulse,
  output logic                            o_hsync,
  output logic                            o_vsync,
  output logic [COLOR_W-1:0]              o_red,
  output logic [COLOR_W-1:0]              o_green,
  output logic [COLOR_W-1:0]              o_blue,
  output logic [9-CONV:0]                 o_hpos,
  output logic [9-CONV:0]                 o_vpos,
  output logic                            o_display_on,
  output logic                            o_frame_tick,
  output logic                            o_game_tick,
  output logic                            o_line_tick,
  output logic                            o_collision,
  output logic [9:0]                      o_coll_hpos,
  output logic [9:0]                      o_coll_vpos
);

  localparam int RGB_W = 3 * COLOR_W;
  localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       display_on;

  vga_timing u_timing (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos),
    .vpos       (vpos),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on)
  );

  assign o_hpos       = hpos[9:CONV];
  assign o_vpos       = vpos[9:CONV];
  assign o_display_on = display_on;

  // Lowest-numbered active layer wins; scanning downwards leaves it last.
  logic [IDX_W-1:0] sel_idx;
  logic             sel_hit;

  always_comb begin
    sel_idx = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (i_layer_on[k]) sel_idx = IDX_W'(k);
    end
  end

  assign sel_hit = |i_layer_on;

  // Stage 1: winning layer, hit flag, active-area valid and raw syncs
  logic [IDX_W-1:0] idx_p1;
  logic             hit_p1;
  logic             vld_p1;
  logic             hsync_p1;
  logic             vsync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_p1   <= '0;
      hit_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
    end else begin
      idx_p1   <= sel_idx;
      hit_p1   <= sel_hit;
      vld_p1   <= display_on;
      hsync_p1 <= hsync;
      vsync_p1 <= vsync;
    end
  end

  // Stage 2: palette lookup (palette sampled here), blanking and aligned syncs
  logic [RGB_W-1:0] pal_entry;
  logic [RGB_W-1:0] rgb_p2;
  logic             hsync_p2;
  logic             vsync_p2;

  assign pal_entry = RGB_W'(color_slice(PAL_MAX_W'(i_palette), 32'(idx_p1), COLOR_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p2   <= '0;
      hsync_p2 <= 1'b1;
      vsync_p2 <= 1'b1;
    end else begin
      rgb_p2   <= !vld_p1 ? '0 : (hit_p1 ? pal_entry : i_bg_color);
      hsync_p2 <= hsync_p1;
      vsync_p2 <= vsync_p1;
    end
  end

  assign o_red   = rgb_p2[RGB_W-1 -: COLOR_W];
  assign o_green = rgb_p2[2*COLOR_W-1 -: COLOR_W];
  assign o_blue  = rgb_p2[COLOR_W-1:0];
  assign o_hsync = hsync_p2;
  assign o_vsync = vsync_p2;

  logic [3:0] frame_cnt;
  logic       line_q;

  assign o_frame_tick = !rst && (hpos == 10'd0) && (vpos == 10'd0);
  assign o_game_tick  = o_frame_tick && (frame_cnt == 4'(TICK_DIV - 1));
  assign o_line_tick  = vpos[LINE_BIT] && !line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      line_q    <= 1'b0;
    end else begin
      line_q <= vpos[LINE_BIT];
      if (o_frame_tick) frame_cnt <= o_game_tick ? 4'd0 : frame_cnt + 4'd1;
    end
  end

  // Collision uses undelayed hits so the capture matches the live counters.
  logic coll_hit;

  assign coll_hit = display_on && |(i_layer_on & COLL_MASK_A) && |(i_layer_on & COLL_MASK_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_collision <= 1'b0;
      o_coll_hpos <= '0;
      o_coll_vpos <= '0;
    end else if (i_game_start_pulse) begin
      o_collision <= 1'b0;
    end else if (coll_hit && !o_collision) begin
      o_collision <= 1'b1;
      o_coll_hpos <= hpos;
      o_coll_vpos <= vpos;
    end
  end

endmodule

// File: tb/tb_graphics_compositor.sv
// Bench for graphics_compositor: a position-table of directed pixels plus
// random layer hits, all compared each cycle with a raster-arithmetic model.
module tb_graphics_compositor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  layer_on = '0;
  logic [23:0] palette;
  logic [5:0]  bg;
  logic        start = 1'b0;

  logic       hs, vs, disp, ft, gt, lt, coll;
  logic [1:0] red, green, blue;
  logic [9:0] hp, vp, chp, cvp;

  logic       hs1, vs1, disp1, ft1, gt1, lt1, coll1;
  logic [1:0] red1, green1, blue1;
  logic [9:0] hp1, vp1, chp1, cvp1;

  always #5 clk = ~clk;

  graphics_compositor u_dut (
    .clk(clk), .rst(rst), .i_layer_on(layer_on), .i_palette(palette),
    .i_bg_color(bg), .i_game_start_pulse(start),
    .o_hsync(hs), .o_vsync(vs), .o_red(red), .o_green(green), .o_blue(blue),
    .o_hpos(hp), .o_vpos(vp), .o_display_on(disp),
    .o_frame_tick(ft), .o_game_tick(gt), .o_line_tick(lt),
    .o_collision(coll), .o_coll_hpos(chp), .o_coll_vpos(cvp)
  );

  graphics_compositor #(.TICK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_layer_on(layer_on), .i_palette(palette),
    .i_bg_color(bg), .i_game_start_pulse(start),
    .o_hsync(hs1), .o_vsync(vs1), .o_red(red1), .o_green(green1), .o_blue(blue1),
    .o_hpos(hp1), .o_vpos(vp1), .o_display_on(disp1),
    .o_frame_tick(ft1), .o_game_tick(gt1), .o_line_tick(lt1),
    .o_collision(coll1), .o_coll_hpos(chp1), .o_coll_vpos(cvp1)
  );

  typedef struct {
    int         h;
    int         v;
    logic [3:0] lay;
    logic [5:0] rgb;
  } vec_t;

  localparam int NVEC = 13;
  localparam int TDIV = 3;

  vec_t       vecs [NVEC];
  logic [5:0] pal_arr [4];
  logic [3:0] lay_hist [4];

  int checks = 0;
  int errors = 0;
  int n = 0;
  int frames = 0;
  logic model_coll = 1'b0;
  int   model_ch = 0;
  int   model_cv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  function automatic logic is_active(input int h, input int v);
    return (h < 640) && (v < 480);
  endfunction

  function automatic logic [5:0] model_rgb(input int h, input int v, input logic [3:0] lay);
    if (!is_active(h, v)) return 6'd0;
    for (int k = 0; k < 4; k++) if (lay[k]) return pal_arr[k];
    return bg;
  endfunction

  task automatic reset_model();
    n = 0;
    frames = 0;
    model_coll = 1'b0;
    model_ch = 0;
    model_cv = 0;
  endtask

  task automatic run_cycles(input int count);
    for (int c = 0; c < count; c++) begin
      int h, v, mh, mv;
      logic [3:0] lay;
      logic found, exp_ft, exp_gt, exp_lt, exp_hs, exp_vs;
      logic [5:0] exp_rgb;
      h = n % 800;
      v = (n / 800) % 525;
      found = 1'b0;
      lay = 4'($urandom_range(0, 15));
      if (is_active(h, v) && lay[1:0] == 2'b11) lay[1] = 1'b0;
      for (int i = 0; i < NVEC; i++) begin
        if (vecs[i].h == h && vecs[i].v == v) begin
          lay = vecs[i].lay;
          found = 1'b1;
        end
      end
      layer_on = lay;
      start = (h == 300 && v == 70);
      lay_hist[n % 4] = lay;

      @(negedge clk);
      chk("pos", 32'({hp, vp, disp}), 32'({10'(h), 10'(v), is_active(h, v)}));
      if (n < 2) begin
        exp_hs = 1'b1;
        exp_vs = 1'b1;
        exp_rgb = 6'd0;
      end else begin
        mh = (n - 2) % 800;
        mv = ((n - 2) / 800) % 525;
        exp_hs = !(mh >= 656 && mh <= 751);
        exp_vs = !(mv >= 490 && mv <= 491);
        exp_rgb = model_rgb(mh, mv, lay_hist[(n - 2) % 4]);
        for (int i = 0; i < NVEC; i++)
          if (vecs[i].h == mh && vecs[i].v == mv) chk("vec_rgb", 32'({red, green, blue}), 32'(vecs[i].rgb));
      end
      chk("sync", 32'({hs, vs}), 32'({exp_hs, exp_vs}));
      chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
      exp_ft = (h == 0 && v == 0);
      exp_gt = exp_ft && (frames % TDIV == TDIV - 1);
      exp_lt = (h == 0) && (v % 64 == 32);
      chk("ticks", 32'({ft, gt, lt}), 32'({exp_ft, exp_gt, exp_lt}));
      chk("ticks_div1", 32'({ft1, gt1}), 32'({exp_ft, exp_ft}));
      chk("coll", 32'({coll, chp, cvp}), 32'({model_coll, 10'(model_ch), 10'(model_cv)}));
      if (h == 201 && v == 60) chk("cap_first", 32'({coll, chp, cvp}), 32'({1'b1, 10'd100, 10'd50}));
      if (h == 301 && v == 70) chk("start_clear", 32'(coll), 32'(0));
      if (h == 701 && v == 10) chk("blank_coll", 32'(coll), 32'(0));

      if (exp_ft) frames++;
      if (start) model_coll = 1'b0;
      else if (is_active(h, v) && lay[1] && lay[0] && !model_coll) begin
        model_coll = 1'b1;
        model_ch = h;
        model_cv = v;
      end
      if (!found) lay = lay;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(0));
    chk({tag, "_sync"}, 32'({hs, vs}), 32'(2'b11));
    chk({tag, "_ticks"}, 32'({ft, gt, lt, ft1, gt1}), 32'(0));
    chk({tag, "_coll"}, 32'({coll, chp, cvp}), 32'(0));
    chk({tag, "_pos"}, 32'({hp, vp}), 32'(0));
  endtask

  initial begin
    pal_arr[0] = 6'b000011;
    pal_arr[1] = 6'b110000;
    pal_arr[2] = 6'b001100;
    pal_arr[3] = 6'b010101;
    palette = {pal_arr[3], pal_arr[2], pal_arr[1], pal_arr[0]};
    bg = 6'b100110;

    vecs[0]  = '{10,  0,  4'b0110, 6'b110000};
    vecs[1]  = '{11,  0,  4'b0000, 6'b100110};
    vecs[2]  = '{12,  0,  4'b1000, 6'b010101};
    vecs[3]  = '{13,  0,  4'b0101, 6'b000011};
    vecs[4]  = '{639, 0,  4'b0100, 6'b001100};
    vecs[5]  = '{640, 0,  4'b0100, 6'b000000};
    vecs[6]  = '{799, 1,  4'b1000, 6'b000000};
    vecs[7]  = '{0,   2,  4'b1000, 6'b010101};
    vecs[8]  = '{700, 10, 4'b0011, 6'b000000};
    vecs[9]  = '{100, 50, 4'b0011, 6'b000011};
    vecs[10] = '{200, 60, 4'b0011, 6'b000011};
    vecs[11] = '{300, 70, 4'b0011, 6'b000011};
    vecs[12] = '{400, 80, 4'b0011, 6'b000011};
    for (int i = 0; i < 4; i++) lay_hist[i] = '0;

    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    run_cycles(78000);

    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_state("midreset_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_model();
    run_cycles(900);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/graphics_compositor.md
Name: graphics_compositor

Overview:
Parametrised successor to the single-colour graphics front end. It generates VGA 640x480 timing internally and composites N prioritised sprite/layer hit flags into COLOR_W-bit RGB using a per-layer palette. Sync outputs are delayed to stay aligned with the RGB pipeline. It also produces the frame, game and line ticks and a masked collision detector that captures the first collision position. It sits between the game-logic/sprite generators and the VGA pins.

Parameters:
N_LAYERS, 4, number of layer hit inputs; index 0 is highest priority (range 1..8)
COLOR_W, 2, bits per colour channel
CONV, 0, LSBs dropped from exported o_hpos/o_vpos
TICK_DIV, 3, number of frames per game tick (1..15)
LINE_BIT, 5, vpos bit whose rising edge produces o_line_tick
COLL_MASK_A, 4'b0010, layers forming collision group A (player)
COLL_MASK_B, 4'b0001, layers forming collision group B (obstacle)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
i_layer_on  in  N_LAYERS  per-layer hit for the pixel at current o_hpos/o_vpos (combinational from those)
i_palette  in  N_LAYERS*3*COLOR_W  per-layer {R,G,B}, layer k at bits [k*3*COLOR_W +: 3*COLOR_W]
i_bg_color  in  3*COLOR_W  {R,G,B} used when no layer hits
i_game_start_pulse  in  1  clears collision state
o_hsync, o_vsync  out  1  active-low syncs, pipeline-aligned
o_red, o_green, o_blue  out  COLOR_W  registered pixel colour
o_hpos, o_vpos  out  10-CONV  current counters [9:CONV]
o_display_on  out  1  undelayed active-area flag
o_frame_tick, o_game_tick, o_line_tick  out  1  single-cycle pulses
o_collision  out  1  sticky collision flag
o_coll_hpos, o_coll_vpos  out  10  position of first collision since clear

Behaviour:
- Timing: hpos counts 0..799 and wraps; vpos increments on the hpos wrap and counts 0..524. Active area: hpos<640 && vpos<480. hsync low for hpos 656..751; vsync low for vpos 490..491.
- Reset (async): counters=0; pipeline regs cleared; RGB=0; o_hsync=o_vsync=1; all ticks 0; o_collision=0; capture regs=0; frame counter=0.
- Pipeline, latency 2 cycles from counters to RGB/syncs:
  - S1 registers the index of the lowest-numbered active layer, a hit flag, display_on, hsync and vsync.
  - S2 registers the palette entry for that layer (or i_bg_color if no hit), forced to 0 when the delayed display_on is 0, plus the delayed syncs.
  - Palette is sampled at S2.
- o_frame_tick = (hpos==0 && vpos==0), not during reset.
- Frame counter increments on each frame tick and wraps at TICK_DIV-1. o_game_tick = o_frame_tick && count==TICK_DIV-1 before the increment. With TICK_DIV=1 it fires every frame.
- o_line_tick is high for one cycle when vpos[LINE_BIT] is 1 and its registered copy is 0.
- Collision evaluates in the current cycle from undelayed inputs: hit = display_on && |(i_layer_on & COLL_MASK_A) && |(i_layer_on & COLL_MASK_B).
  - On a hit with o_collision=0: set o_collision, capture hpos/vpos.
  - Later hits do not update the capture.
  - i_game_start_pulse has priority: it clears o_collision (capture regs keep their value). A hit in the same cycle is ignored.
- Reset mid-frame: all state returns to reset values immediately; timing restarts at (0,0) on the first clock after release, and o_frame_tick fires in that cycle.
- Masks with overlapping bits are legal: a single layer in both masks collides with itself.

Decomposition:
- Package graphics_pkg holds the timing constants (H_ACTIVE=640, H_SYNC_START=656, H_SYNC_END=751, H_TOTAL=800, V_ACTIVE=480, V_SYNC_START=490, V_SYNC_END=491, V_TOTAL=525) and a 3*COLOR_W colour-slice helper function.
- One sub-module, vga_timing: counters, syncs and display_on, with clk/rst.
- Priority encoder, pipeline, ticks and collision stay in the top module.

Test Plan:
- Reset held for 5 cycles, then released -> RGB=0, syncs=1, o_collision=0 during reset; o_frame_tick=1 on the first post-release cycle, with o_hpos=o_vpos=0.
- i_layer_on=4'b0110, layer1 palette=6'b110000, layer2 palette=6'b001100, at hpos=10 -> RGB={11,00,00} two cycles later; with i_layer_on=0 -> i_bg_color.
- Count cycles from hpos=656 -> o_hsync falls at hpos=658 and stays low for 96 cycles; RGB is 0 whenever delayed display_on=0 (hpos 642..801 relative to S0).
- Run 7 frames with TICK_DIV=3 -> o_game_tick on frames 2 and 5 (0-based frame-tick count), exactly one cycle each; o_line_tick once at each vpos 32, 96, ... 480 within a frame.
- Assert layers 0 and 1 together at (hpos=100, vpos=50), then again at (200, 60) -> o_collision=1, capture=(100, 50), unchanged after the second hit.
- Then pulse i_game_start_pulse while collision inputs stay active in that cycle -> o_collision=0 next cycle.
- Collision asserted only while hpos=700 (blanking) -> no collision.
